main_ctr: RTL and testbench
===========================

Name: main_ctr

Overview:
- Main control unit of the single-issue MIPS-subset datapath.
- Decodes the 6-bit opcode and 6-bit function field into datapath control strobes:
  - register destination select
  - ALU operand select
  - memory-to-register select
  - register-file write enable
  - data-memory write enable
  - branch-equal flag
  - 2-bit ALU operation code
- Outputs are registered, so the block sits between the instruction register and the datapath.
- Supported instructions: addu, subu, ori, lw, sw, beq, lui.

Parameters:
- None. All encodings are fixed constants.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  instruction opcode field [31:26].
- fun  input  6  instruction function field [5:0]; used only when op = 000000.
- RegDst  output  1  1 = write register is rd; 0 = write register is rt.
- AluSrc  output  1  1 = ALU operand B is the immediate; 0 = operand B is rt.
- MemtoReg  output  1  1 = register write data comes from data memory.
- RegWrite  output  1  register-file write enable.
- MemWrite  output  1  data-memory write enable.
- IBeq  output  1  instruction is beq; the datapath ANDs it with the ALU zero flag.
- AluCtr  output  2  ALU operation: 00 add, 01 sub, 10 or, 11 lui (imm << 16).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset:
  - While reset = 1, all outputs are 0: RegDst, AluSrc, MemtoReg, RegWrite, MemWrite and IBeq are 0, and AluCtr = 00.
  - Reset asserted mid-operation clears the outputs immediately, with no clock edge required.
  - After reset deasserts, the first rising edge loads the decode of the current op/fun.
- Latency:
  - op/fun are sampled at each rising clk edge.
  - The decoded controls appear on the outputs after that edge and hold for one full cycle. Latency is 1 cycle.
  - No handshake. Every edge loads a new decode.
- Decode table (RegDst AluSrc MemtoReg RegWrite MemWrite IBeq, then AluCtr):
  - op 000000, fun 100001 (addu): 1 0 0 1 0 0, AluCtr 00
  - op 000000, fun 100011 (subu): 1 0 0 1 0 0, AluCtr 01
  - op 001101 (ori): 0 1 0 1 0 0, AluCtr 10
  - op 100011 (lw): 0 1 1 1 0 0, AluCtr 00
  - op 101011 (sw): 0 1 0 0 1 0, AluCtr 00
  - op 000100 (beq): 0 0 0 0 0 1, AluCtr 01
  - op 001111 (lui): 0 1 0 1 0 0, AluCtr 11
- fun is ignored for every op other than 000000.
- Unrecognized op, or op = 000000 with any other fun (including the nop all-zero word), registers all-zero outputs. This guarantees no register or memory write.
- RegWrite and MemWrite are never 1 in the same cycle.
- IBeq = 1 only for beq.

Decomposition:
- Shared package (mips_pkg) holds:
  - opcode constants: OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI
  - funct constants: FN_ADDU, FN_SUBU
  - AluCtr encodings: ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI
- Datapath and ALU reuse the same package.
- One natural sub-module, main_ctr_decode: a purely combinational op/fun to control-vector decoder. main_ctr wraps it with the async-reset output register.

Test Plan:
- Assert reset with op = 000000, fun = 100001 -> all outputs 0 immediately. Release reset; next posedge -> RegDst=1, AluSrc=0, MemtoReg=0, RegWrite=1, MemWrite=0, IBeq=0, AluCtr=00.
- Sequence, one instruction per posedge: subu (000000/100011), ori (001101), lw (100011), sw (101011), beq (000100), lui (001111). One edge after each -> outputs match the decode table row. Specifically:
  - subu: AluCtr=01, RegWrite=1
  - ori: AluSrc=1, AluCtr=10
  - lw: MemtoReg=1, RegWrite=1
  - sw: MemWrite=1, RegWrite=0
  - beq: IBeq=1, AluCtr=01
  - lui: AluCtr=11
- fun don't-care: op = 001101 with fun = 100011 -> same outputs as ori (AluCtr=10). op = 000000 with fun = 000000 -> all-zero outputs.
- Unknown op 111111 and R-type fun 001000 -> all-zero outputs, RegWrite=0, MemWrite=0.
- Latency check: change op between edges -> outputs do not change until the next rising edge.
- Async reset pulse mid-cycle while decoding sw -> MemWrite drops to 0 before the next edge. After release, sw is decoded again at the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the MIPS-subset control unit, datapath and ALU.
//   - Opcode and funct constants for the supported instructions.
//   - AluCtr encodings understood by the ALU.
//   - ctrl_t: the registered control vector produced by main_ctr.
package mips_pkg;

    // Opcode field [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Function field [5:0], meaningful only for OP_RTYPE
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       ibeq;
        logic [1:0] alu_ctr;
    } ctrl_t;

    // Safe vector: no register write, no memory write, no branch.
    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/main_ctr_if.sv
// main_ctr_if: instruction fields in, datapath control strobes out.
//   op/fun   : opcode and function fields of the current instruction
//   RegDst, AluSrc, MemtoReg, RegWrite, MemWrite, IBeq, AluCtr : controls
// master = instruction side (drives op/fun), slave = main_ctr.
interface main_ctr_if;
    logic [5:0] op;
    logic [5:0] fun;
    logic       RegDst;
    logic       AluSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemWrite;
    logic       IBeq;
    logic [1:0] AluCtr;

    modport master (
        output op, fun,
        input  RegDst, AluSrc, MemtoReg, RegWrite, MemWrite, IBeq, AluCtr
    );

    modport slave (
        input  op, fun,
        output RegDst, AluSrc, MemtoReg, RegWrite, MemWrite, IBeq, AluCtr
    );
endinterface

// File: rtl/main_ctr_decode.sv
// main_ctr_decode: purely combinational op/fun -> control vector decoder.
//   op   : opcode field
//   fun  : function field (ignored unless op is R-type)
//   ctrl : decoded control vector; unknown encodings yield CTRL_NONE
module main_ctr_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fun,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                // Any R-type funct other than addu/subu (nop included)
                // stays at CTRL_NONE so nothing gets written.
                case (fun)
                    FN_ADDU: ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0,
                                      reg_write: 1'b1, mem_write: 1'b0, ibeq: 1'b0,
                                      alu_ctr: ALU_ADD};
                    FN_SUBU: ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0,
                                      reg_write: 1'b1, mem_write: 1'b0, ibeq: 1'b0,
                                      alu_ctr: ALU_SUB};
                    default: ctrl = CTRL_NONE;
                endcase
            end
            OP_ORI:  ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0,
                              reg_write: 1'b1, mem_write: 1'b0, ibeq: 1'b0,
                              alu_ctr: ALU_OR};
            OP_LW:   ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1,
                              reg_write: 1'b1, mem_write: 1'b0, ibeq: 1'b0,
                              alu_ctr: ALU_ADD};
            OP_SW:   ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0,
                              reg_write: 1'b0, mem_write: 1'b1, ibeq: 1'b0,
                              alu_ctr: ALU_ADD};
            OP_BEQ:  ctrl = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
                              reg_write: 1'b0, mem_write: 1'b0, ibeq: 1'b1,
                              alu_ctr: ALU_SUB};
            OP_LUI:  ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0,
                              reg_write: 1'b1, mem_write: 1'b0, ibeq: 1'b0,
                              alu_ctr: ALU_LUI};
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/main_ctr.sv
// main_ctr: main control unit of the MIPS-subset datapath.
//   clk   : rising-edge clock; op/fun sampled every edge (1-cycle latency)
//   reset : asynchronous active-high; forces all controls to 0 at once
//   bus   : main_ctr_if.slave carrying op/fun in and the registered controls out
module main_ctr
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    main_ctr_if.slave   bus
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    main_ctr_decode u_decode (
        .op   (bus.op),
        .fun  (bus.fun),
        .ctrl (dec_ctrl)
    );

    // No handshake: every edge captures a fresh decode.
    always_comb begin
        ctrl_d = dec_ctrl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctrl_q <= CTRL_NONE;
        else       ctrl_q <= ctrl_d;
    end

    assign bus.RegDst   = ctrl_q.reg_dst;
    assign bus.AluSrc   = ctrl_q.alu_src;
    assign bus.MemtoReg = ctrl_q.mem_to_reg;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.IBeq     = ctrl_q.ibeq;
    assign bus.AluCtr   = ctrl_q.alu_ctr;

endmodule

// File: tb/tb_main_ctr.sv
// tb_main_ctr: directed bench for main_ctr with a rule-based reference model
// compared every negedge, plus hand-computed literal checks.
// Vector order: {RegDst, AluSrc, MemtoReg, RegWrite, MemWrite, IBeq, AluCtr[1:0]}
module tb_main_ctr;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errs;
    logic [7:0] exp_q;

    main_ctr_if bus ();

    main_ctr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [7:0] dut_vec = {bus.RegDst, bus.AluSrc, bus.MemtoReg, bus.RegWrite,
                          bus.MemWrite, bus.IBeq, bus.AluCtr};

    // Reference: each control expressed as the set of instructions that assert it.
    function automatic logic [7:0] model(input logic [5:0] op, input logic [5:0] fun);
        logic addu, subu, ori, lw, sw, beq, lui;
        logic [1:0] alu;
        addu = (op == 6'd0) && (fun == 6'b100001);
        subu = (op == 6'd0) && (fun == 6'b100011);
        ori  = (op == 6'b001101);
        lw   = (op == 6'b100011);
        sw   = (op == 6'b101011);
        beq  = (op == 6'b000100);
        lui  = (op == 6'b001111);
        if (subu || beq) alu = 2'd1;
        else if (ori)    alu = 2'd2;
        else if (lui)    alu = 2'd3;
        else             alu = 2'd0;
        return {addu | subu, ori | lw | sw | lui, lw,
                addu | subu | ori | lw | lui, sw, beq, alu};
    endfunction

    // Expected registered value: what the model said at the last edge, or 0 under reset.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_q <= 8'h00;
        else       exp_q <= model(bus.op, bus.fun);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+2; applies op/fun, checks one edge later, returns at posedge+2.
    task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fun,
                         input logic [7:0] exp);
        bus.op  = op;
        bus.fun = fun;
        @(posedge clk);
        #1;
        check(name, dut_vec, exp);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        reset    = 1'b1;
        bus.op   = 6'b000000;
        bus.fun  = 6'b100001;

        fork
            forever begin
                @(negedge clk);
                check("model", dut_vec, exp_q);
                if (bus.RegWrite && bus.MemWrite)
                    check("wr_exclusive", 8'd1, 8'd0);
            end
        join_none

        #1;
        check("reset_zero", dut_vec, 8'b0000_0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", dut_vec, 8'b0000_0000);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("addu", dut_vec, 8'b1001_0000);
        #1;

        apply("subu",      6'b000000, 6'b100011, 8'b1001_0001);
        apply("ori",       6'b001101, 6'b000000, 8'b0101_0010);
        apply("lw",        6'b100011, 6'b000000, 8'b0111_0000);
        apply("sw",        6'b101011, 6'b000000, 8'b0100_1000);
        apply("beq",       6'b000100, 6'b000000, 8'b0000_0101);
        apply("lui",       6'b001111, 6'b000000, 8'b0101_0011);
        apply("ori_fun",   6'b001101, 6'b100011, 8'b0101_0010);
        apply("nop",       6'b000000, 6'b000000, 8'b0000_0000);
        apply("lw_fun",    6'b100011, 6'b100001, 8'b0111_0000);
        apply("op_unk",    6'b111111, 6'b100001, 8'b0000_0000);
        apply("fun_unk",   6'b000000, 6'b001000, 8'b0000_0000);
        apply("addu2",     6'b000000, 6'b100001, 8'b1001_0000);

        // Inputs change mid-cycle: outputs must hold until the next edge.
        bus.op  = 6'b101011;
        bus.fun = 6'b000000;
        #1;
        check("hold_mid", dut_vec, 8'b1001_0000);
        @(posedge clk);
        #1;
        check("sw_after", dut_vec, 8'b0100_1000);
        #1;

        // Async reset pulse mid-cycle while sw is on the outputs.
        reset = 1'b1;
        #1;
        check("async_clr", dut_vec, 8'b0000_0000);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("sw_redo", dut_vec, 8'b0100_1000);
        #1;

        apply("beq2",      6'b000100, 6'b111111, 8'b0000_0101);
        apply("lui2",      6'b001111, 6'b100011, 8'b0101_0011);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
